// File: rtl/diff_comb_lagged_pkg.sv
// diff_comb_lagged_pkg
//   Shared constants and arithmetic helpers for the lagged comb differentiator.
//   - Default parameter values (sample width, delay depth, shift, lag width).
//   - fits_signed : does a sign-extended value fit in a w-bit signed field.
//   - sat_or_wrap : saturate to the w-bit signed range, or pass through for
//                   the caller to truncate (wrap).
//   - clamp_lag   : map a requested lag onto 1..max_lag.
package diff_comb_lagged_pkg;

  localparam int W_DEFAULT       = 8;
  localparam int MAX_LAG_DEFAULT = 8;
  localparam int SHIFT_DEFAULT   = 1;
  localparam int LAG_W_DEFAULT   = $clog2(MAX_LAG_DEFAULT) + 1;

  // Width of the internal scratch format used by the helpers; sample
  // widths up to ARITH_W-2 are supported.
  localparam int ARITH_W = 64;

  function automatic logic fits_signed(input logic signed [ARITH_W-1:0] s,
                                       input int w);
    logic signed [ARITH_W-1:0] hi_v;
    logic signed [ARITH_W-1:0] lo_v;
    hi_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_v = -hi_v - 64'sd1;
    return (s <= hi_v) && (s >= lo_v);
  endfunction

  // Out-of-range values either clip to the nearest limit (sat_en=1) or are
  // returned unchanged so that the caller's truncation to w bits wraps them.
  function automatic logic signed [ARITH_W-1:0] sat_or_wrap(
      input logic signed [ARITH_W-1:0] s,
      input int                        w,
      input logic                      sat_en);
    logic signed [ARITH_W-1:0] hi_v;
    logic signed [ARITH_W-1:0] r_v;
    hi_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (fits_signed(s, w)) begin
      r_v = s;
    end else if (sat_en) begin
      r_v = (s < 64'sd0) ? (-hi_v - 64'sd1) : hi_v;
    end else begin
      r_v = s;
    end
    return r_v;
  endfunction

  // A lag of zero would compare a sample with itself; treat it as one.
  function automatic logic [31:0] clamp_lag(input logic [31:0] lag,
                                            input logic [31:0] max_lag);
    logic [31:0] r_v;
    if (lag == 32'd0) begin
      r_v = 32'd1;
    end else if (lag > max_lag) begin
      r_v = max_lag;
    end else begin
      r_v = lag;
    end
    return r_v;
  endfunction

endpackage

// File: rtl/diff_comb_lagged_lag_delay_line.sv
// diff_comb_lagged_lag_delay_line
//   MAX_LAG x W circular sample buffer. The read port returns the sample
//   written lag_off writes ago (lag_off=0 means MAX_LAG ago), read in the same
//   cycle as the new sample is written, so it sees the value before the write.
// Ports:
//   clk, reset  : clock, async active-high reset (pointer only)
//   clear       : synchronous pointer restart
//   wr_en       : write wr_data at the pointer and advance it
//   lag_off     : read offset behind the write pointer (mod MAX_LAG)
//   wr_data     : sample to store
//   rd_data     : delayed sample
module diff_comb_lagged_lag_delay_line
  import diff_comb_lagged_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int MAX_LAG = MAX_LAG_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LAG)-1:0] lag_off,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data
);

  localparam int PTR_W = $clog2(MAX_LAG);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_idx_s;
  logic [W-1:0]     mem_r [MAX_LAG];

  // Power-of-two depth makes the modular subtraction a plain wrap-around.
  assign rd_idx_s = wr_ptr_r - lag_off;
  assign rd_data  = mem_r[rd_idx_s];

  // Write pointer: restarts on reset/clear, advances on every write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
    end else if (wr_en) begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Sample storage; contents are never reset since warm-up hides stale data.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/diff_comb_lagged.sv
// diff_comb_lagged
//   Streaming comb differentiator: y[n] = (x[n] - x[n-L]) >>> SHIFT on signed
//   samples, with runtime lag L (1..MAX_LAG), saturate-or-wrap output, sticky
//   overflow flag and valid/ready handshakes on both sides. The first L
//   samples after reset/clear only prime the delay line and produce no output.
// Ports:
//   clk, reset          : clock, async active-high reset
//   clear               : synchronous restart, reloads the lag from 'lag'
//   lag                 : requested lag, sampled only while clear=1
//   sat_en              : 1 saturate, 0 wrap on overflow
//   in_valid/in_ready   : input handshake, in_data signed sample
//   out_valid/out_ready : output handshake, out_data signed result
//   ovf                 : sticky overflow since reset/clear
module diff_comb_lagged
  import diff_comb_lagged_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int MAX_LAG = MAX_LAG_DEFAULT,
  parameter int SHIFT   = SHIFT_DEFAULT,
  parameter int LAG_W   = $clog2(MAX_LAG) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [LAG_W-1:0] lag,
  input  logic             sat_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             ovf
);

  localparam int PTR_W = $clog2(MAX_LAG);

  logic                      out_valid_r;
  logic [W-1:0]              out_data_r;
  logic                      ovf_r;
  logic [LAG_W-1:0]          lag_q_r;
  logic [LAG_W-1:0]          count_r;

  logic                      xfer_s;
  logic [W-1:0]              x_old_s;
  logic signed [W:0]         d_s;
  logic signed [W:0]         s_s;
  logic signed [ARITH_W-1:0] s_wide_s;
  logic                      ovf_s;
  logic [W-1:0]              res_s;

  // A held output blocks new input so nothing is overwritten.
  assign in_ready  = !clear && (!out_valid_r || out_ready);
  assign xfer_s    = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign ovf       = ovf_r;

  diff_comb_lagged_lag_delay_line #(
    .W       (W),
    .MAX_LAG (MAX_LAG)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (xfer_s),
    .lag_off (lag_q_r[PTR_W-1:0]),
    .wr_data (in_data),
    .rd_data (x_old_s)
  );

  // Difference in W+1 bits cannot overflow; the shift floors toward -inf.
  always_comb begin
    d_s      = $signed({in_data[W-1], in_data}) - $signed({x_old_s[W-1], x_old_s});
    s_s      = d_s >>> SHIFT;
    s_wide_s = {{(ARITH_W-W-1){s_s[W]}}, s_s};
    ovf_s    = !fits_signed(s_wide_s, W);
    res_s    = W'(sat_or_wrap(s_wide_s, W, sat_en));
  end

  // Handshake, warm-up counter, result register and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      ovf_r       <= 1'b0;
      count_r     <= '0;
      lag_q_r     <= LAG_W'(1);
    end else if (clear) begin
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      count_r     <= '0;
      lag_q_r     <= LAG_W'(clamp_lag(32'(lag), 32'(MAX_LAG)));
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (xfer_s) begin
        if (count_r < lag_q_r) begin
          count_r <= count_r + LAG_W'(1);
        end else begin
          out_valid_r <= 1'b1;
          out_data_r  <= res_s;
          if (ovf_s) begin
            ovf_r <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_diff_comb_lagged.sv
// tb_diff_comb_lagged
//   Drives two instances (SHIFT=1 and SHIFT=0) with identical stimulus and
//   compares both against a sample-history model every cycle, plus literal
//   expectations for the directed scenarios.
module tb_diff_comb_lagged;

  localparam int W       = 8;
  localparam int MAX_LAG = 8;
  localparam int LAG_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic [LAG_W-1:0] lag = '0;
  logic             sat_en = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a, out_valid_a, ovf_a;
  logic [W-1:0]     out_data_a;
  logic             in_ready_b, out_valid_b, ovf_b;
  logic [W-1:0]     out_data_b;

  diff_comb_lagged #(.W(W), .MAX_LAG(MAX_LAG), .SHIFT(1), .LAG_W(LAG_W)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .lag(lag), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .ovf(ovf_a));

  diff_comb_lagged #(.W(W), .MAX_LAG(MAX_LAG), .SHIFT(0), .LAG_W(LAG_W)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .lag(lag), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .ovf(ovf_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: accepted samples since reset/clear, current lag, output regs.
  int hist[$];
  int m_lag;
  bit m_valid;
  int m_data[2];
  bit m_ovf[2];
  int got_a[$];
  int got_b[$];
  bit last_rdy;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int got[$], input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(name, got[i], exp[i]);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference arithmetic: floor-shifted difference, then saturate or wrap.
  function automatic int ref_out(input int d, input int sh, input bit sat, output bit of);
    int s;
    s  = d >>> sh;
    of = (s > 127) || (s < -128);
    if (of && sat) s = (s > 0) ? 127 : -128;
    else if (of) begin
      s = s & 255;
      if (s > 127) s = s - 256;
    end
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_lag   = 1;
    m_valid = 1'b0;
    m_data  = '{0, 0};
    m_ovf   = '{1'b0, 1'b0};
  endtask

  task automatic check_outputs();
    chk("out_valid_a", int'(out_valid_a), int'(m_valid));
    chk("out_valid_b", int'(out_valid_b), int'(m_valid));
    chk("ovf_a", int'(ovf_a), int'(m_ovf[0]));
    chk("ovf_b", int'(ovf_b), int'(m_ovf[1]));
    if (m_valid) begin
      chk("out_data_a", sval(out_data_a), m_data[0]);
      chk("out_data_b", sval(out_data_b), m_data[1]);
    end
  endtask

  // One clock: check state, drive inputs, check in_ready, advance the model.
  task automatic cycle(input bit clr, input int lg, input bit sat, input bit iv,
                       input int id, input bit ordy);
    bit rdy;
    bit of;
    int xo;
    @(negedge clk);
    check_outputs();
    clear     = clr;
    lag       = LAG_W'(lg);
    sat_en    = sat;
    in_valid  = iv;
    in_data   = W'(id);
    out_ready = ordy;
    #1;
    rdy = !clr && (!m_valid || ordy);
    chk("in_ready_a", int'(in_ready_a), int'(rdy));
    chk("in_ready_b", int'(in_ready_b), int'(rdy));
    if (!clr && out_valid_a && ordy) got_a.push_back(sval(out_data_a));
    if (!clr && out_valid_b && ordy) got_b.push_back(sval(out_data_b));
    last_rdy = rdy;
    if (clr) begin
      hist.delete();
      m_valid = 1'b0;
      m_ovf   = '{1'b0, 1'b0};
      m_lag   = (lg == 0) ? 1 : ((lg > MAX_LAG) ? MAX_LAG : lg);
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (iv && rdy) begin
        if (hist.size() >= m_lag) begin
          xo = hist[hist.size() - m_lag];
          for (int k = 0; k < 2; k++) begin
            m_data[k] = ref_out(id - xo, (k == 0) ? 1 : 0, sat, of);
            if (of) m_ovf[k] = 1'b1;
          end
          m_valid = 1'b1;
        end
        hist.push_back(id);
        if (hist.size() > 16) void'(hist.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
  endtask

  task automatic restart(input int lg, input bit sat);
    cycle(1'b1, lg, sat, 1'b0, 0, 1'b1);
    got_a.delete();
    got_b.delete();
  endtask

  // Offer samples back-to-back; out_ready is low for cycles stall_lo..stall_hi.
  task automatic stream(input int s[$], input bit sat, input int stall_lo, input int stall_hi);
    int idx = 0;
    for (int c = 0; c < 100 && idx < s.size(); c++) begin
      cycle(1'b0, int'($urandom_range(15, 0)), sat, 1'b1, s[idx],
            !(c >= stall_lo && c <= stall_hi));
      if (last_rdy) idx++;
    end
    chk("stream_accepted", idx, s.size());
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_valid_a", int'(out_valid_a), 0);
    chk("areset_out_data_a", int'(out_data_a), 0);
    chk("areset_ovf_a", int'(ovf_a), 0);
    chk("areset_out_valid_b", int'(out_valid_b), 0);
    chk("areset_out_data_b", int'(out_data_b), 0);
    in_valid = 1'b0;
    clear    = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    int s[$];
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid_a), 0);
    chk("reset_out_data", int'(out_data_a), 0);
    chk("reset_ovf", int'(ovf_a), 0);
    chk("reset_in_ready", int'(in_ready_a), 1);
    reset = 1'b0;

    // Lag 1, basic differences including a negative floor.
    restart(1, 1'b1);
    s = '{10, 30, 20, -1};
    stream(s, 1'b1, 100, 100);
    idle(3);
    exp_q = '{10, -5, -11};
    chk_q("t1_a", got_a, exp_q);
    exp_q = '{20, -10, -21};
    chk_q("t1_b", got_b, exp_q);
    chk("t1_ovf", int'(ovf_a), 0);

    // Lag 4 warm-up, then one result per cycle.
    restart(4, 1'b1);
    s = '{1, 2, 3, 4, 5, 6, 7, 8};
    stream(s, 1'b1, 100, 100);
    idle(3);
    exp_q = '{2, 2, 2, 2};
    chk_q("t2_a", got_a, exp_q);
    exp_q = '{4, 4, 4, 4};
    chk_q("t2_b", got_b, exp_q);

    // Overflow: saturate, then wrap.
    restart(1, 1'b1);
    s = '{127, -128};
    stream(s, 1'b1, 100, 100);
    idle(2);
    exp_q = '{-128};
    chk_q("t3_sat_b", got_b, exp_q);
    chk_q("t3_sat_a", got_a, exp_q);
    chk("t3_sat_ovf_b", int'(ovf_b), 1);
    chk("t3_sat_ovf_a", int'(ovf_a), 0);
    restart(1, 1'b0);
    stream(s, 1'b0, 100, 100);
    idle(2);
    exp_q = '{1};
    chk_q("t3_wrap_b", got_b, exp_q);
    chk("t3_wrap_ovf_b", int'(ovf_b), 1);

    // Backpressure with lag 2.
    restart(2, 1'b1);
    s = '{5, 9, 14, 20, 27, 35, 44};
    stream(s, 1'b1, 3, 5);
    idle(3);
    exp_q = '{4, 5, 6, 7, 8};
    chk_q("t4_a", got_a, exp_q);

    // Mid-stream clear to lag 8 with input still valid, then async reset.
    restart(2, 1'b1);
    s.delete();
    for (int i = 0; i < 6; i++) s.push_back(int'($urandom_range(255, 0)) - 128);
    stream(s, 1'b1, 100, 100);
    cycle(1'b1, 8, 1'b1, 1'b1, 77, 1'b1);
    chk("t5_ovf_after_clear", int'(ovf_a), 0);
    got_a.delete();
    s.delete();
    for (int i = 0; i < 10; i++) s.push_back(int'($urandom_range(255, 0)) - 128);
    stream(s, 1'b1, 100, 100);
    chk("t5_warmup_outputs", got_a.size(), 1);
    async_reset();

    // Lag clamping.
    restart(0, 1'b1);
    s = '{3, 7, 4};
    stream(s, 1'b1, 100, 100);
    idle(2);
    exp_q = '{2, -2};
    chk_q("t6_lag0_a", got_a, exp_q);
    restart(12, 1'b1);
    s.delete();
    for (int i = 0; i < 12; i++) s.push_back(i * 3);
    stream(s, 1'b1, 100, 100);
    idle(3);
    exp_q = '{12, 12, 12, 12};
    chk_q("t6_lag12_a", got_a, exp_q);
    exp_q = '{24, 24, 24, 24};
    chk_q("t6_lag12_b", got_b, exp_q);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(39, 0) == 0), int'($urandom_range(15, 0)),
            bit'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0),
            int'($urandom_range(255, 0)) - 128, ($urandom_range(3, 0) != 0));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
